// File: rtl/instr_exec_controller_pkg.sv
// rtl/instr_exec_controller_pkg.sv - shared opcodes, FSM states and instruction field positions
package instr_exec_controller_pkg;

  localparam int INSTR_W = 8;

  // Instruction layout: op[7:6], rd[5:4], rs[3:2], rt[1:0]; LI reuses {rs,rt} as imm[3:0]
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int RT_MSB  = 1;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LI  = 2'b10,
    OP_AND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    DECODE    = 2'b01,
    EXECUTE   = 2'b10,
    WRITEBACK = 2'b11
  } state_t;

  function automatic op_t instr_op(input logic [INSTR_W-1:0] word);
    return op_t'(word[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/instr_exec_controller_if.sv
// rtl/instr_exec_controller_if.sv - instruction handshake and register-file bus
interface instr_exec_controller_if #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2,
  parameter int PC_W       = 8
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [7:0]            instr;
  logic [REG_ADDR_W-1:0] read_reg1;
  logic [REG_ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0]     reg_data1;
  logic [DATA_W-1:0]     reg_data2;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic                  signal_regwrite;
  logic [PC_W-1:0]       pc;
  logic                  busy;

  // master: the controller; slave: upstream source plus register file
  modport master (
    input  instr_valid, instr, reg_data1, reg_data2,
    output instr_ready, read_reg1, read_reg2, write_reg, write_data,
           signal_regwrite, pc, busy
  );

  modport slave (
    output instr_valid, instr, reg_data1, reg_data2,
    input  instr_ready, read_reg1, read_reg2, write_reg, write_data,
           signal_regwrite, pc, busy
  );
endinterface

// File: rtl/instr_exec_controller_alu_8bit.sv
// rtl/instr_exec_controller_alu_8bit.sv - combinational ALU: ADD/SUB/LI/AND with carry-or-borrow out
module alu_8bit
  import instr_exec_controller_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] wide;

  // carry is the ADD carry-out or the SUB borrow; zero for LI and AND
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_LI:  result = DATA_W'(imm);
      OP_AND: result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_controller.sv
// rtl/instr_exec_controller.sv - 4-cycle fetch/decode/execute/writeback controller; INSTR_EXEC_OVERFLOW_FLAG_EN adds a sticky overflow output
module instr_exec_controller
  import instr_exec_controller_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2,
  parameter int PC_W       = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  instr_exec_controller_if.master   bus
`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
  ,
  output logic                      overflow
`endif
);

  state_t                state_q, state_d;
  logic [INSTR_W-1:0]    ir_q;
  logic [DATA_W-1:0]     result_q;
  logic [REG_ADDR_W-1:0] write_reg_q;
  logic                  regwrite_q;
  logic [PC_W-1:0]       pc_q;
  logic                  accept;
  op_t                   op;
  logic [DATA_W-1:0]     alu_result;
  logic                  alu_carry;

  assign op     = instr_op(ir_q);
  assign accept = bus.instr_valid && (state_q == FETCH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     if (accept) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  alu_8bit #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (bus.reg_data1),
    .b      (bus.reg_data2),
    .imm    (ir_q[IMM_MSB:IMM_LSB]),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Write address/data are captured at the EXECUTE edge and held afterwards;
  // regwrite_q is high only during WRITEBACK since EXECUTE always leads there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q        <= '0;
      result_q    <= '0;
      write_reg_q <= '0;
      regwrite_q  <= 1'b0;
      pc_q        <= '0;
    end else begin
      regwrite_q <= (state_q == EXECUTE);
      if (accept) begin
        ir_q <= bus.instr;
        pc_q <= pc_q + 1'b1;
      end
      if (state_q == EXECUTE) begin
        result_q    <= alu_result;
        write_reg_q <= ir_q[RD_MSB:RD_LSB];
      end
    end
  end

`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (state_q == EXECUTE && (op == OP_ADD || op == OP_SUB) && alu_carry)
      overflow <= 1'b1;
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  // Read addresses come straight from the latched word, so they hold through EXECUTE
  assign bus.read_reg1       = ir_q[RS_MSB:RS_LSB];
  assign bus.read_reg2       = ir_q[RT_MSB:RT_LSB];
  assign bus.write_reg       = write_reg_q;
  assign bus.write_data      = result_q;
  assign bus.signal_regwrite = regwrite_q;
  assign bus.pc              = pc_q;
  assign bus.instr_ready     = (state_q == FETCH);
  assign bus.busy            = (state_q != FETCH);

endmodule

// File: tb/tb_instr_exec_controller.sv
// tb/tb_instr_exec_controller.sv - directed and random checks against a reference model
module tb_instr_exec_controller;

  logic clock;
  logic reset_n;
`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
  logic overflow;
`endif

  instr_exec_controller_if #(.DATA_W(8), .REG_ADDR_W(2), .PC_W(8)) bus ();

  instr_exec_controller #(.DATA_W(8), .REG_ADDR_W(2), .PC_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
    ,
    .overflow(overflow)
`endif
  );

  // Register file model: combinational reads, write on the clock edge
  logic [7:0] rf [4];
  assign bus.reg_data1 = rf[bus.read_reg1];
  assign bus.reg_data2 = rf[bus.read_reg2];
  always @(posedge clock)
    if (bus.signal_regwrite) rf[bus.write_reg] <= bus.write_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ref_rf [4];
  int pc_exp = 0;
  bit ovf_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Spec-level instruction semantics; returns the result and updates the overflow expectation
  function automatic int ref_exec(input logic [7:0] ins);
    int a, b, r;
    a = ref_rf[ins[3:2]];
    b = ref_rf[ins[1:0]];
    case (ins[7:6])
      2'd0: begin r = (a + b) % 256; if (a + b > 255) ovf_exp = 1; end
      2'd1: begin r = (a - b + 256) % 256; if (a < b) ovf_exp = 1; end
      2'd2: r = int'(ins[3:0]);
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.instr_ready && n < 10) begin
      tick();
      n++;
    end
    chk(tag, bus.instr_ready, 1);
  endtask

  task automatic run_instr(input logic [7:0] ins);
    int exp;
    int rd;
    rd = int'(ins[5:4]);
    wait_ready("ready_before_accept");
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    exp    = ref_exec(ins);
    pc_exp = (pc_exp + 1) % 256;
    tick();
    bus.instr_valid = 1'b0;
    chk("decode_busy", bus.busy, 1);
    chk("decode_ready", bus.instr_ready, 0);
    chk("decode_rs", bus.read_reg1, ins[3:2]);
    chk("decode_rt", bus.read_reg2, ins[1:0]);
    chk("decode_regwrite", bus.signal_regwrite, 0);
    chk("pc", bus.pc, pc_exp);
    tick();
    chk("execute_rs", bus.read_reg1, ins[3:2]);
    chk("execute_regwrite", bus.signal_regwrite, 0);
    tick();
    chk("wb_regwrite", bus.signal_regwrite, 1);
    chk("wb_reg", bus.write_reg, rd);
    chk("wb_data", bus.write_data, exp);
    tick();
    ref_rf[rd] = exp;
    chk("post_regwrite", bus.signal_regwrite, 0);
    chk("post_ready", bus.instr_ready, 1);
    chk("post_data_hold", bus.write_data, exp);
    chk("rf_written", rf[rd], exp);
`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
    chk("overflow", overflow, ovf_exp);
`endif
  endtask

  logic [7:0] prog [3];
  int acc_cyc [3];

  initial begin
    for (int i = 0; i < 4; i++) begin
      rf[i] = 8'h00;
      ref_rf[i] = 0;
    end
    reset_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    tick();
    tick();
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_regwrite", bus.signal_regwrite, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_read_reg1", bus.read_reg1, 0);
`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
    chk("rst_overflow", overflow, 0);
`endif
    reset_n = 1'b1;
    tick();

    // Directed: LI r1,5 then ADD r2=r1+r1
    run_instr(8'b10_01_01_01);
    chk("li_pc", bus.pc, 1);
    chk("li_r1", rf[1], 8'h05);
    run_instr(8'b00_10_01_01);
    chk("add_r2", rf[2], 8'h0A);

    // SUB wrap: r0=0, r1=1, r3=r0-r1
    run_instr(8'b10_00_00_00);
    run_instr(8'b10_01_00_01);
    run_instr(8'b01_11_00_01);
    chk("sub_r3", rf[3], 8'hFF);
`ifdef INSTR_EXEC_OVERFLOW_FLAG_EN
    chk("sub_overflow", overflow, 1);
    run_instr(8'b11_00_00_00);
    chk("overflow_sticky", overflow, 1);
`endif

    // Reset while signal_regwrite is high: LI r2,7 must not land
    wait_ready("ready_before_abort");
    bus.instr_valid = 1'b1;
    bus.instr = 8'b10_10_01_11;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    chk("abort_wb_regwrite", bus.signal_regwrite, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_regwrite_drop", bus.signal_regwrite, 0);
    chk("abort_pc", bus.pc, 0);
    chk("abort_ready", bus.instr_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    pc_exp = 0;
    ovf_exp = 0;
    chk("abort_r2_unchanged", rf[2], ref_rf[2]);
    chk("abort_r2_value", rf[2], 8'h0A);

    // Back-to-back with instr_valid held high
    prog[0] = 8'b10_01_01_01;
    prog[1] = 8'b00_10_01_01;
    prog[2] = 8'b11_00_11_10;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int exp;
      int rd;
      bus.instr = prog[k];
      wait_ready("b2b_ready");
      exp = ref_exec(prog[k]);
      rd = int'(prog[k][5:4]);
      tick();
      acc_cyc[k] = cyc;
      chk("b2b_busy_after_accept", bus.instr_ready, 0);
      ref_rf[rd] = exp;
      pc_exp = (pc_exp + 1) % 256;
    end
    bus.instr_valid = 1'b0;
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 4);
    chk("b2b_pc", bus.pc, 3);
    tick();
    tick();
    tick();
    chk("b2b_r2", rf[2], 8'h0A);
    chk("b2b_r0", rf[0], 8'h0A);
    chk("b2b_r0_model", rf[0], ref_rf[0]);

    // Random instructions with idle gaps; 256 accepts walks pc once around
    for (int i = 0; i < 256; i++) begin
      int idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) tick();
      run_instr(8'($urandom));
    end
    chk("pc_wrapped", bus.pc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
